// File: rtl/e203_csr_arb_pkg.sv
// rtl/e203_csr_arb_pkg.sv - shared op, source and state encodings for the CSR access arbiter
package e203_csr_arb_pkg;

    localparam int OP_RW = 0;
    localparam int OP_RS = 1;
    localparam int OP_RC = 2;

    localparam logic SRC_CORE = 1'b0;
    localparam logic SRC_DBG  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

endpackage

// File: rtl/e203_csr_wdat_merge.sv
// rtl/e203_csr_wdat_merge.sv - RW/RS/RC merge of operand with the current CSR value
module e203_csr_wdat_merge
    import e203_csr_arb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] opnd,
    input  logic [XLEN-1:0] read_csr_dat,
    output logic [XLEN-1:0] wbck_csr_dat
);

    always_comb begin
        wbck_csr_dat = ~opnd & read_csr_dat;
        if (op[OP_RW]) begin
            wbck_csr_dat = opnd;
        end else if (op[OP_RS]) begin
            wbck_csr_dat = opnd | read_csr_dat;
        end
    end

endmodule

// File: rtl/e203_csr_access_arb.sv
// rtl/e203_csr_access_arb.sv - core/debug arbiter for the CSR file port with registered response
// Optional core anti-starvation counter: E203_CSR_ARB_STARVE_EN
module e203_csr_access_arb
    import e203_csr_arb_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            core_req_valid,
    output logic            core_req_ready,
    input  logic [2:0]      core_req_op,
    input  logic [11:0]     core_req_idx,
    input  logic [XLEN-1:0] core_req_opnd,
    input  logic            core_req_rdwen,
    input  logic            core_req_rs1is0,
    output logic            core_rsp_valid,
    input  logic            core_rsp_ready,
    output logic [XLEN-1:0] core_rsp_rdata,
    output logic            core_rsp_err,
    input  logic            dbg_req_valid,
    output logic            dbg_req_ready,
    input  logic [2:0]      dbg_req_op,
    input  logic [11:0]     dbg_req_idx,
    input  logic [XLEN-1:0] dbg_req_opnd,
    input  logic            dbg_req_rdwen,
    input  logic            dbg_req_rs1is0,
    output logic            dbg_rsp_valid,
    input  logic            dbg_rsp_ready,
    output logic [XLEN-1:0] dbg_rsp_rdata,
    output logic            dbg_rsp_err,
    output logic            csr_ena,
    output logic            csr_rd_en,
    output logic            csr_wr_en,
    output logic [11:0]     csr_idx,
    output logic [XLEN-1:0] wbck_csr_dat,
    input  logic [XLEN-1:0] read_csr_dat,
    input  logic            csr_access_ilgl
);

    if ((1 << CNT_W) <= STARVE_LIMIT) begin : g_bad_cnt_w
        $error("CNT_W too narrow for STARVE_LIMIT");
    end

    state_t          state;
    state_t          state_nxt;
    logic            rsp_src;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic            rsp_hs;
    logic            issue;
    logic            force_core;
    logic            win_dbg;

    logic [2:0]      sel_op;
    logic [11:0]     sel_idx;
    logic [XLEN-1:0] sel_opnd;
    logic            sel_rdwen;
    logic            sel_rs1is0;
    logic            op_ok;
    logic            rd_raw;
    logic            wr_raw;
    logic [XLEN-1:0] merged_dat;

    // A pending response that handshakes this cycle frees the port for back-to-back issue.
    assign rsp_hs = (state == ST_RESP) &
                    ((rsp_src == SRC_DBG) ? dbg_rsp_ready : core_rsp_ready);
    assign issue  = ((state == ST_IDLE) | rsp_hs) & (core_req_valid | dbg_req_valid);

`ifdef E203_CSR_ARB_STARVE_EN
    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!core_req_valid || core_req_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != {CNT_W{1'b1}}) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    assign force_core = core_req_valid & (starve_cnt >= CNT_W'(STARVE_LIMIT));
`else
    assign force_core = 1'b0;
`endif

    assign win_dbg = dbg_req_valid & ~force_core;

    assign sel_op     = win_dbg ? dbg_req_op      : core_req_op;
    assign sel_idx    = win_dbg ? dbg_req_idx     : core_req_idx;
    assign sel_opnd   = win_dbg ? dbg_req_opnd    : core_req_opnd;
    assign sel_rdwen  = win_dbg ? dbg_req_rdwen   : core_req_rdwen;
    assign sel_rs1is0 = win_dbg ? dbg_req_rs1is0  : core_req_rs1is0;

    assign op_ok  = (sel_op == 3'b001) | (sel_op == 3'b010) | (sel_op == 3'b100);
    assign rd_raw = sel_op[OP_RS] | sel_op[OP_RC] | (sel_op[OP_RW] & sel_rdwen);
    assign wr_raw = sel_op[OP_RW] | ((sel_op[OP_RS] | sel_op[OP_RC]) & ~sel_rs1is0);

    e203_csr_wdat_merge #(.XLEN(XLEN)) u_wdat_merge (
        .op           (sel_op),
        .opnd         (sel_opnd),
        .read_csr_dat (read_csr_dat),
        .wbck_csr_dat (merged_dat)
    );

    assign core_req_ready = issue & ~win_dbg;
    assign dbg_req_ready  = issue & win_dbg;
    assign csr_ena        = issue;
    assign csr_rd_en      = issue & op_ok & rd_raw;
    assign csr_wr_en      = issue & op_ok & wr_raw & ~csr_access_ilgl;
    assign csr_idx        = issue ? sel_idx : 12'h000;
    assign wbck_csr_dat   = issue ? merged_dat : '0;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue) state_nxt = ST_RESP;
            ST_RESP: begin
                if (issue) begin
                    state_nxt = ST_RESP;
                end else if (rsp_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rsp_src     <= SRC_CORE;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                rsp_src     <= win_dbg ? SRC_DBG : SRC_CORE;
                rsp_rdata_q <= (csr_rd_en & ~csr_access_ilgl) ? read_csr_dat : '0;
                rsp_err_q   <= csr_access_ilgl | ~op_ok;
            end
        end
    end

    assign core_rsp_valid = (state == ST_RESP) & (rsp_src == SRC_CORE);
    assign dbg_rsp_valid  = (state == ST_RESP) & (rsp_src == SRC_DBG);
    assign core_rsp_rdata = core_rsp_valid ? rsp_rdata_q : '0;
    assign dbg_rsp_rdata  = dbg_rsp_valid  ? rsp_rdata_q : '0;
    assign core_rsp_err   = core_rsp_valid & rsp_err_q;
    assign dbg_rsp_err    = dbg_rsp_valid  & rsp_err_q;

endmodule
